tag_logic: RTL and testbench

//  Per-buffer tag state machine for double-buffered scratchpads: one instance per tag slot.

---
 rtl/tag_logic_pkg.sv | 13 +
 rtl/tag_logic.sv | 117 +++++++++++
 tb/tb_tag_logic.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tag_logic_pkg.sv
// Shared definitions for the per-slot tag state machine.
package tag_logic_pkg;

  localparam int TAG_STATE_W = 2;

  typedef enum logic [TAG_STATE_W-1:0] {
    TAG_FREE    = 2'd0,
    TAG_LDMEM   = 2'd1,
    TAG_COMPUTE = 2'd2,
    TAG_STMEM   = 2'd3
  } tag_state_e;

endpackage

// File: rtl/tag_logic.sv
// Per-buffer tag slot: FREE -> LDMEM -> COMPUTE -> STMEM -> FREE, with a
// pending-reuse counter that holds the slot in COMPUTE for extra passes.
module tag_logic
  import tag_logic_pkg::*;
#(
  parameter int REUSE_CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tag_req,
  input  logic tag_reuse,
  input  logic tag_bias_prev_sw,
  input  logic tag_ddr_pe_sw,
  input  logic tag_done,
  input  logic tag_flush,
  input  logic next_sync_compute_tag,
  input  logic ldmem_tag_done,
  input  logic compute_tag_done,
  input  logic stmem_tag_done,
  output logic tag_ready,
  output logic ldmem_tag_ready,
  output logic compute_tag_ready,
  output logic stmem_tag_ready,
  output logic next_compute_tag,
  output logic compute_bias_prev_sw,
  output logic stmem_ddr_pe_sw
);

  localparam logic [REUSE_CNT_W-1:0] CNT_MAX = '1;

  tag_state_e             state_q, state_d;
  logic                   flush_q, flush_d;
  logic [REUSE_CNT_W-1:0] reuse_cnt_q, reuse_cnt_d;
  logic                   bias_sw_q, bias_sw_d;
  logic                   ddr_sw_q, ddr_sw_d;

  logic reuse_inc;
  logic reuse_dec;
  logic exit_compute;
  logic tag_done_unused;

  assign tag_done_unused = tag_done;

  // A same-cycle reuse is counted before the compute pass consumes one, so it
  // both blocks the exit and cancels the decrement.
  assign reuse_inc = tag_reuse & ~next_sync_compute_tag &
                     ((state_q == TAG_LDMEM) | (state_q == TAG_COMPUTE));
  assign reuse_dec = (state_q == TAG_COMPUTE) & compute_tag_done &
                     ((reuse_cnt_q != '0) | reuse_inc);
  assign exit_compute = (state_q == TAG_COMPUTE) & compute_tag_done &
                        (reuse_cnt_q == '0) & ~reuse_inc & (flush_q | tag_flush);

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    reuse_cnt_d = reuse_cnt_q;
    bias_sw_d   = bias_sw_q;
    ddr_sw_d    = ddr_sw_q;

    if (reuse_inc && !reuse_dec) begin
      if (reuse_cnt_q != CNT_MAX) reuse_cnt_d = reuse_cnt_q + 1'b1;
    end else if (reuse_dec && !reuse_inc) begin
      reuse_cnt_d = reuse_cnt_q - 1'b1;
    end

    if (tag_flush && (state_q != TAG_FREE)) flush_d = 1'b1;

    unique case (state_q)
      TAG_FREE: begin
        if (tag_req) begin
          state_d   = TAG_LDMEM;
          bias_sw_d = tag_bias_prev_sw;
          ddr_sw_d  = tag_ddr_pe_sw;
        end
      end
      TAG_LDMEM: begin
        if (ldmem_tag_done) state_d = TAG_COMPUTE;
      end
      TAG_COMPUTE: begin
        if (exit_compute) state_d = TAG_STMEM;
      end
      TAG_STMEM: begin
        if (stmem_tag_done) begin
          state_d     = TAG_FREE;
          flush_d     = 1'b0;
          reuse_cnt_d = '0;
        end
      end
      default: state_d = TAG_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TAG_FREE;
      flush_q     <= 1'b0;
      reuse_cnt_q <= '0;
      bias_sw_q   <= 1'b0;
      ddr_sw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      reuse_cnt_q <= reuse_cnt_d;
      bias_sw_q   <= bias_sw_d;
      ddr_sw_q    <= ddr_sw_d;
    end
  end

  assign tag_ready            = (state_q == TAG_FREE);
  assign ldmem_tag_ready      = (state_q == TAG_LDMEM);
  assign compute_tag_ready    = (state_q == TAG_COMPUTE);
  assign stmem_tag_ready      = (state_q == TAG_STMEM);
  assign next_compute_tag     = exit_compute;
  assign compute_bias_prev_sw = bias_sw_q;
  assign stmem_ddr_pe_sw      = ddr_sw_q;

endmodule

// File: tb/tb_tag_logic.sv
// Randomized and directed bench for tag_logic against a slot-level reference model.
module tb_tag_logic;

  localparam int REUSE_CNT_W = 4;
  localparam int PEND_MAX    = (1 << REUSE_CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tag_done, tag_flush;
  logic next_sync_compute_tag, ldmem_tag_done, compute_tag_done, stmem_tag_done;
  logic tag_ready, ldmem_tag_ready, compute_tag_ready, stmem_tag_ready;
  logic next_compute_tag, compute_bias_prev_sw, stmem_ddr_pe_sw;

  int total = 0;
  int bad   = 0;

  // Reference model: phase name, number of extra passes owed, flush seen, switches.
  int m_phase;  // 0 free, 1 load, 2 compute, 3 store
  int m_pend;
  bit m_flush, m_bias, m_ddr;

  tag_logic #(.REUSE_CNT_W(REUSE_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .tag_req(tag_req), .tag_reuse(tag_reuse),
    .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
    .tag_done(tag_done), .tag_flush(tag_flush),
    .next_sync_compute_tag(next_sync_compute_tag),
    .ldmem_tag_done(ldmem_tag_done), .compute_tag_done(compute_tag_done),
    .stmem_tag_done(stmem_tag_done),
    .tag_ready(tag_ready), .ldmem_tag_ready(ldmem_tag_ready),
    .compute_tag_ready(compute_tag_ready), .stmem_tag_ready(stmem_tag_ready),
    .next_compute_tag(next_compute_tag),
    .compute_bias_prev_sw(compute_bias_prev_sw), .stmem_ddr_pe_sw(stmem_ddr_pe_sw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_flush = 0; m_bias = 0; m_ddr = 0;
  endtask

  function automatic bit model_leaves();
    int owed;
    owed = m_pend + ((tag_reuse && !next_sync_compute_tag) ? 1 : 0);
    return (m_phase == 2) && compute_tag_done && (owed == 0) && (m_flush || tag_flush);
  endfunction

  task automatic model_clock();
    int owed;
    bit counts;
    counts = tag_reuse && !next_sync_compute_tag && (m_phase == 1 || m_phase == 2);
    owed = m_pend + (counts ? 1 : 0);
    if (m_phase != 0 && tag_flush) m_flush = 1;
    case (m_phase)
      0: if (tag_req) begin
           m_phase = 1; m_bias = tag_bias_prev_sw; m_ddr = tag_ddr_pe_sw;
         end
      1: if (ldmem_tag_done) m_phase = 2;
      2: if (compute_tag_done) begin
           if (owed == 0) begin
             if (m_flush) m_phase = 3;
           end else owed = owed - 1;
         end
      default: if (stmem_tag_done) begin
           m_phase = 0; m_flush = 0; owed = 0;
         end
    endcase
    m_pend = (owed > PEND_MAX) ? PEND_MAX : owed;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_tag_ready"},   32'(tag_ready),         32'(m_phase == 0));
    check({pfx, "_ld_ready"},    32'(ldmem_tag_ready),   32'(m_phase == 1));
    check({pfx, "_cmp_ready"},   32'(compute_tag_ready), 32'(m_phase == 2));
    check({pfx, "_st_ready"},    32'(stmem_tag_ready),   32'(m_phase == 3));
    check({pfx, "_bias_sw"},     32'(compute_bias_prev_sw), 32'(m_bias));
    check({pfx, "_ddr_sw"},      32'(stmem_ddr_pe_sw),      32'(m_ddr));
  endtask

  // One clock: drive at negedge, check the combinational exit, clock, check state.
  task automatic drive(input bit req, input bit reuse, input bit bias, input bit ddr,
                       input bit fl, input bit sync, input bit ld, input bit cd, input bit sd);
    @(negedge clk);
    tag_req = req; tag_reuse = reuse; tag_bias_prev_sw = bias; tag_ddr_pe_sw = ddr;
    tag_flush = fl; next_sync_compute_tag = sync; ldmem_tag_done = ld;
    compute_tag_done = cd; stmem_tag_done = sd; tag_done = 1'($urandom_range(0, 1));
    #1;
    check("next_compute_tag", 32'(next_compute_tag), 32'(model_leaves()));
    @(posedge clk);
    model_clock();
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    tag_req = 0; tag_reuse = 0; tag_bias_prev_sw = 0; tag_ddr_pe_sw = 0; tag_done = 0;
    tag_flush = 0; next_sync_compute_tag = 0; ldmem_tag_done = 0;
    compute_tag_done = 0; stmem_tag_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_nct", 32'(next_compute_tag), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain pass with both switches set and flush on the only compute pass.
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
    check("s1_in_store", 32'(stmem_tag_ready), 32'd1);
    check("s1_ddr_sw", 32'(stmem_ddr_pe_sw), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("s1_free", 32'(tag_ready), 32'd1);

    // Two reuses while loading: three compute passes before leaving.
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("s2_still_compute", 32'(compute_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("s2_store", 32'(stmem_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reuse coinciding with the array-wide sync pulse is dropped.
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
    check("s3_store", 32'(stmem_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Compute finishes without flush: waits; flush later releases it.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s4_waiting", 32'(compute_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
    check("s4_store", 32'(stmem_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reuse on the same cycle as the last compute pass blocks the exit.
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    check("s5_blocked", 32'(compute_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("s5_store", 32'(stmem_tag_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset while computing takes effect before the next edge.
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    tag_reuse = 0; ldmem_tag_done = 0; compute_tag_done = 0; tag_req = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async");
    check("async_nct", 32'(next_compute_tag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Random traffic, biased so that slots cycle through all phases.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
